coco_kbd_matrix: RTL and testbench
==================================

# coco_kbd_matrix

Converts MiSTer `ps2_key` events from `hps_io` into the CoCo 2 7×8 keyboard matrix that the core's PIA reads. It sits directly downstream of `hps_io` and upstream of the core's keyboard port. It holds per-key state and answers column-strobe reads with active-low row data. A minimum-hold timer stretches short taps so that a single CPU scan cannot miss them.

## Interface
- `HOLD_CYCLES`, default 1_000_000: minimum clk_sys cycles a pressed key stays asserted (20 ms at 50 MHz); must be ≥1.
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `ps2_key`  in  11  hps_io format:
  - [10] toggle strobe
  - [9] 1 = press, 0 = release
  - [8] extended (E0) code
  - [7:0] set-2 scancode
- `col_strobe_n`  in  8  PIA PB column drive, active-low; several bits may be low at once.
- `row_n`  out  7  PIA PA row return, active-low, registered.
- `key_valid`  out  1  one-cycle pulse when an event mapped to a matrix position.

## Operation
- Matrix layout, row r / column c (column = PB bit):
  - r0: @ A B C D E F G
  - r1: H–O
  - r2: P–W
  - r3: X Y Z UP DOWN LEFT RIGHT SPACE
  - r4: 0–7
  - r5: 8 9 : ; , - . /
  - r6: ENTER CLEAR BREAK ALT CTRL F1 F2 SHIFT
- Key mapping:
  - Letters, digits, space and enter map to their set-2 codes.
  - Both shifts (12, 59) map to SHIFT; ESC (76) maps to BREAK; E0 6C (Home) maps to CLEAR.
  - Arrows are E0 75/72/6B/74.
  - Unmapped codes are ignored: no state change, no `key_valid`.
- Event detect:
  - `tog_q` registers `ps2_key[10]`; an event fires when `ps2_key[10] != tog_q`.
  - On reset release, `tog_q` loads the current `ps2_key[10]` in the first clock; no spurious event.
- Pipeline:
  - S0: event captured into `ev_q` (press, ext, code).
  - S1: lookup gives {hit, row[2:0], col[2:0]}; `key_valid` pulses.
  - S2: matrix bit update.
- Hold slot: one slot {row, col, cnt, defer}.
  - A mapped press sets the matrix bit, loads the slot with that position, sets cnt = HOLD_CYCLES, and clears defer.
  - A mapped release for a position ≠ slot position, or with cnt == 0, clears the bit immediately.
  - A mapped release for the slot position while cnt > 0 sets defer; the bit stays set.
  - cnt decrements to 0 and saturates there. On the cycle cnt goes 1→0 with defer = 1, the bit clears and defer clears.
  - A new press while slot defer = 1 first clears the old slot's bit in the same cycle, then loads the slot with the new key. If the new key is the same key, the bit stays set.
  - A press of an already-set key reloads cnt.
  - SHIFT from either shift key is one bit: releasing one shift clears SHIFT even if the other is still held.
- Read: `row_n[r]` is the registered value of `~|(matrix[r] & ~col_strobe_n)`. `col_strobe_n` = 8'hFF gives `row_n` = 7'h7F.

## Timing
- Reset values:
  - `row_n` = 7'h7F, `key_valid` = 0, matrix all 0.
  - Slot cnt = 0, defer = 0, `tog_q` = 0.
- Toggle edge sampled at cycle N:
  - `key_valid` high in cycle N+2.
  - Matrix updated at the N+2 edge.
  - `row_n` reflects it at N+3 (given a steady strobe).
- Strobe change to `row_n` is 1 cycle.
- Back-to-back toggles on consecutive cycles are all processed in order; the pipeline never stalls.
- Reset asserted mid-pipeline or mid-hold discards in-flight events and pending releases.

## Structure
- Package `coco_kbd_pkg`:
  - `kbd_pos_t` {row[2:0], col[2:0]}
  - scancode localparams
  - row/column constants for SHIFT, BREAK, CLEAR and the arrows
- Sub-module `ps2_to_coco`: combinational case lookup {ext, code} → {hit, kbd_pos_t}, registered in S1 by the parent.
- Parent holds the toggle detect, pipeline, 56-bit matrix, hold slot and row-read register.

## Test plan
Bench uses `HOLD_CYCLES` = 8.
- Press A (toggle, `ps2_key[9:0]` = 10'h21C), `col_strobe_n` = 8'hFD → `key_valid` at N+2; `row_n` = 7'h7E at N+3. With strobe 8'hFE → 7'h7F.
- Press A, release A 2 cycles later → `row_n[0]` stays low until cnt expires, then returns high.
- Press E0 75 (UP), strobe 8'hF7 → `row_n` = 7'h77; release after 20 cycles → 7'h7F three cycles after that toggle.
- Press LSHIFT + RSHIFT, release RSHIFT, strobe 8'h7F → `row_n[6]` = 1 (SHIFT clear).
- Unmapped code 8'h07 press → no `key_valid`; `row_n` = 7'h7F for all 8 single-column strobes.
- Press D, assert reset mid-hold, then release reset → `row_n` = 7'h7F; no event is generated from the toggle level present at reset release.

Source files
------------

// File: rtl/coco_kbd_pkg.sv
// Shared types, set-2 scancodes and matrix positions for the CoCo keyboard bridge.
package coco_kbd_pkg;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } kbd_pos_t;

    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_B      = 8'h32;
    localparam logic [7:0] SC_C      = 8'h21;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_E      = 8'h24;
    localparam logic [7:0] SC_F      = 8'h2B;
    localparam logic [7:0] SC_G      = 8'h34;
    localparam logic [7:0] SC_H      = 8'h33;
    localparam logic [7:0] SC_I      = 8'h43;
    localparam logic [7:0] SC_J      = 8'h3B;
    localparam logic [7:0] SC_K      = 8'h42;
    localparam logic [7:0] SC_L      = 8'h4B;
    localparam logic [7:0] SC_M      = 8'h3A;
    localparam logic [7:0] SC_N      = 8'h31;
    localparam logic [7:0] SC_O      = 8'h44;
    localparam logic [7:0] SC_P      = 8'h4D;
    localparam logic [7:0] SC_Q      = 8'h15;
    localparam logic [7:0] SC_R      = 8'h2D;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_T      = 8'h2C;
    localparam logic [7:0] SC_U      = 8'h3C;
    localparam logic [7:0] SC_V      = 8'h2A;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_X      = 8'h22;
    localparam logic [7:0] SC_Y      = 8'h35;
    localparam logic [7:0] SC_Z      = 8'h1A;
    localparam logic [7:0] SC_0      = 8'h45;
    localparam logic [7:0] SC_1      = 8'h16;
    localparam logic [7:0] SC_2      = 8'h1E;
    localparam logic [7:0] SC_3      = 8'h26;
    localparam logic [7:0] SC_4      = 8'h25;
    localparam logic [7:0] SC_5      = 8'h2E;
    localparam logic [7:0] SC_6      = 8'h36;
    localparam logic [7:0] SC_7      = 8'h3D;
    localparam logic [7:0] SC_8      = 8'h3E;
    localparam logic [7:0] SC_9      = 8'h46;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ESC    = 8'h76;
    // The following are only valid with the E0 prefix.
    localparam logic [7:0] SC_HOME   = 8'h6C;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    localparam kbd_pos_t POS_UP    = {3'd3, 3'd3};
    localparam kbd_pos_t POS_DOWN  = {3'd3, 3'd4};
    localparam kbd_pos_t POS_LEFT  = {3'd3, 3'd5};
    localparam kbd_pos_t POS_RIGHT = {3'd3, 3'd6};
    localparam kbd_pos_t POS_CLEAR = {3'd6, 3'd1};
    localparam kbd_pos_t POS_BREAK = {3'd6, 3'd2};
    localparam kbd_pos_t POS_SHIFT = {3'd6, 3'd7};

    function automatic logic [6:0] hit_at(input logic [2:0] r, input logic [2:0] c);
        return {1'b1, r, c};
    endfunction

endpackage

// File: rtl/ps2_to_coco.sv
// Purpose: set-2 scancode {ext, code} to CoCo matrix position lookup.
// Latency: combinational. Backpressure: none.
module ps2_to_coco
    import coco_kbd_pkg::*;
(
    input  logic     i_ext,
    input  logic [7:0] i_code,
    output logic     o_hit,
    output kbd_pos_t o_pos
);

    logic [6:0] w_lut;

    always_comb begin
        w_lut = 7'd0;
        case ({i_ext, i_code})
            {1'b0, SC_A}:      w_lut = hit_at(3'd0, 3'd1);
            {1'b0, SC_B}:      w_lut = hit_at(3'd0, 3'd2);
            {1'b0, SC_C}:      w_lut = hit_at(3'd0, 3'd3);
            {1'b0, SC_D}:      w_lut = hit_at(3'd0, 3'd4);
            {1'b0, SC_E}:      w_lut = hit_at(3'd0, 3'd5);
            {1'b0, SC_F}:      w_lut = hit_at(3'd0, 3'd6);
            {1'b0, SC_G}:      w_lut = hit_at(3'd0, 3'd7);
            {1'b0, SC_H}:      w_lut = hit_at(3'd1, 3'd0);
            {1'b0, SC_I}:      w_lut = hit_at(3'd1, 3'd1);
            {1'b0, SC_J}:      w_lut = hit_at(3'd1, 3'd2);
            {1'b0, SC_K}:      w_lut = hit_at(3'd1, 3'd3);
            {1'b0, SC_L}:      w_lut = hit_at(3'd1, 3'd4);
            {1'b0, SC_M}:      w_lut = hit_at(3'd1, 3'd5);
            {1'b0, SC_N}:      w_lut = hit_at(3'd1, 3'd6);
            {1'b0, SC_O}:      w_lut = hit_at(3'd1, 3'd7);
            {1'b0, SC_P}:      w_lut = hit_at(3'd2, 3'd0);
            {1'b0, SC_Q}:      w_lut = hit_at(3'd2, 3'd1);
            {1'b0, SC_R}:      w_lut = hit_at(3'd2, 3'd2);
            {1'b0, SC_S}:      w_lut = hit_at(3'd2, 3'd3);
            {1'b0, SC_T}:      w_lut = hit_at(3'd2, 3'd4);
            {1'b0, SC_U}:      w_lut = hit_at(3'd2, 3'd5);
            {1'b0, SC_V}:      w_lut = hit_at(3'd2, 3'd6);
            {1'b0, SC_W}:      w_lut = hit_at(3'd2, 3'd7);
            {1'b0, SC_X}:      w_lut = hit_at(3'd3, 3'd0);
            {1'b0, SC_Y}:      w_lut = hit_at(3'd3, 3'd1);
            {1'b0, SC_Z}:      w_lut = hit_at(3'd3, 3'd2);
            {1'b1, SC_UP}:     w_lut = {1'b1, POS_UP};
            {1'b1, SC_DOWN}:   w_lut = {1'b1, POS_DOWN};
            {1'b1, SC_LEFT}:   w_lut = {1'b1, POS_LEFT};
            {1'b1, SC_RIGHT}:  w_lut = {1'b1, POS_RIGHT};
            {1'b0, SC_SPACE}:  w_lut = hit_at(3'd3, 3'd7);
            {1'b0, SC_0}:      w_lut = hit_at(3'd4, 3'd0);
            {1'b0, SC_1}:      w_lut = hit_at(3'd4, 3'd1);
            {1'b0, SC_2}:      w_lut = hit_at(3'd4, 3'd2);
            {1'b0, SC_3}:      w_lut = hit_at(3'd4, 3'd3);
            {1'b0, SC_4}:      w_lut = hit_at(3'd4, 3'd4);
            {1'b0, SC_5}:      w_lut = hit_at(3'd4, 3'd5);
            {1'b0, SC_6}:      w_lut = hit_at(3'd4, 3'd6);
            {1'b0, SC_7}:      w_lut = hit_at(3'd4, 3'd7);
            {1'b0, SC_8}:      w_lut = hit_at(3'd5, 3'd0);
            {1'b0, SC_9}:      w_lut = hit_at(3'd5, 3'd1);
            {1'b0, SC_ENTER}:  w_lut = hit_at(3'd6, 3'd0);
            {1'b1, SC_HOME}:   w_lut = {1'b1, POS_CLEAR};
            {1'b0, SC_ESC}:    w_lut = {1'b1, POS_BREAK};
            {1'b0, SC_LSHIFT}: w_lut = {1'b1, POS_SHIFT};
            {1'b0, SC_RSHIFT}: w_lut = {1'b1, POS_SHIFT};
            default:           w_lut = 7'd0;
        endcase
    end

    assign o_hit = w_lut[6];
    assign o_pos = w_lut[5:0];

endmodule

// File: rtl/coco_kbd_matrix.sv
// Purpose: ps2_key events into a CoCo 2 7x8 key matrix with minimum key hold.
// Latency: toggle->key_valid 2 cycles, ->row_n 3 cycles; strobe->row_n 1 cycle. Backpressure: none, one event per cycle.
module coco_kbd_matrix
    import coco_kbd_pkg::*;
#(
    parameter int HOLD_CYCLES = 1_000_000
)(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  col_strobe_n,
    output logic [6:0]  row_n,
    output logic        key_valid
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic             r_init;
    logic             r_tog;
    logic             r_ev_vld;
    logic             r_ev_press;
    logic             r_ev_ext;
    logic [7:0]       r_ev_code;
    logic             r_kv;
    logic             r_s1_press;
    kbd_pos_t         r_s1_pos;
    logic [55:0]      r_matrix;
    kbd_pos_t         r_slot_pos;
    logic [CNT_W-1:0] r_cnt;
    logic             r_defer;
    logic [6:0]       r_row_n;

    logic             w_hit;
    kbd_pos_t         w_pos;
    logic [55:0]      w_mat_nxt;
    kbd_pos_t         w_slot_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_defer_nxt;
    logic [6:0]       w_row_n;

    ps2_to_coco u_lut (
        .i_ext  (r_ev_ext),
        .i_code (r_ev_code),
        .o_hit  (w_hit),
        .o_pos  (w_pos)
    );

    // Hold expiry is resolved before the S2 event so a release landing on the
    // last hold cycle sees cnt already at zero and clears straight away.
    always_comb begin
        w_mat_nxt   = r_matrix;
        w_slot_nxt  = r_slot_pos;
        w_cnt_nxt   = r_cnt;
        w_defer_nxt = r_defer;
        if (r_cnt != CNT_ZERO) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE && r_defer) begin
                w_mat_nxt[r_slot_pos] = 1'b0;
                w_defer_nxt           = 1'b0;
            end
        end
        if (r_kv) begin
            if (r_s1_press) begin
                if (w_defer_nxt) begin
                    w_mat_nxt[r_slot_pos] = 1'b0;
                end
                w_mat_nxt[r_s1_pos] = 1'b1;
                w_slot_nxt          = r_s1_pos;
                w_cnt_nxt           = CNT_LOAD;
                w_defer_nxt         = 1'b0;
            end else if (r_s1_pos == r_slot_pos && w_cnt_nxt != CNT_ZERO) begin
                w_defer_nxt = 1'b1;
            end else begin
                w_mat_nxt[r_s1_pos] = 1'b0;
            end
        end
    end

    always_comb begin
        w_row_n = 7'h7F;
        for (int r = 0; r < 7; r++) begin
            w_row_n[r] = ~|(r_matrix[r*8 +: 8] & ~col_strobe_n);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_init     <= 1'b1;
            r_tog      <= 1'b0;
            r_ev_vld   <= 1'b0;
            r_ev_press <= 1'b0;
            r_ev_ext   <= 1'b0;
            r_ev_code  <= 8'd0;
            r_kv       <= 1'b0;
            r_s1_press <= 1'b0;
            r_s1_pos   <= '0;
            r_matrix   <= '0;
            r_slot_pos <= '0;
            r_cnt      <= '0;
            r_defer    <= 1'b0;
            r_row_n    <= 7'h7F;
        end else begin
            // First clock after reset only adopts the current toggle level.
            r_init     <= 1'b0;
            r_tog      <= ps2_key[10];
            r_ev_vld   <= ~r_init & (ps2_key[10] != r_tog);
            r_ev_press <= ps2_key[9];
            r_ev_ext   <= ps2_key[8];
            r_ev_code  <= ps2_key[7:0];
            r_kv       <= r_ev_vld & w_hit;
            r_s1_press <= r_ev_press;
            r_s1_pos   <= w_pos;
            r_matrix   <= w_mat_nxt;
            r_slot_pos <= w_slot_nxt;
            r_cnt      <= w_cnt_nxt;
            r_defer    <= w_defer_nxt;
            r_row_n    <= w_row_n;
        end
    end

    assign row_n     = r_row_n;
    assign key_valid = r_kv;

endmodule

// File: tb/tb_coco_kbd_matrix.sv
// Randomized and directed checks of coco_kbd_matrix against a key-level reference model.
module tb_coco_kbd_matrix;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = 11'd0;
    logic [7:0]  strobe = 8'hFF;
    logic [6:0]  row_n;
    logic        key_valid;

    always #5 clk = ~clk;

    coco_kbd_matrix #(.HOLD_CYCLES(H)) u_dut (
        .clk_sys      (clk),
        .reset        (reset),
        .ps2_key      (ps2_key),
        .col_strobe_n (strobe),
        .row_n        (row_n),
        .key_valid    (key_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: key table in matrix order, key state bits, one hold slot
    // described by the cycle at which its hold time runs out.
    logic [8:0] keytab [56];
    logic [8:0] pool [$];
    bit         mat [7][8];
    int         slot_r, slot_c, slot_exp;
    bit         slot_defer;

    typedef struct {
        int         s;
        bit         press;
        logic [8:0] key;
    } ev_t;
    ev_t evq [$];

    function automatic bit lookup(input logic [8:0] key, output int r, output int c);
        logic [8:0] k;
        k = (key == 9'h059) ? 9'h012 : key;
        r = 0;
        c = 0;
        for (int i = 0; i < 56; i++) begin
            if (keytab[i] == k) begin
                r = i / 8;
                c = i % 8;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic set_row(input int r, input logic [8:0] k0, k1, k2, k3, k4, k5, k6, k7);
        keytab[r*8+0] = k0; keytab[r*8+1] = k1; keytab[r*8+2] = k2; keytab[r*8+3] = k3;
        keytab[r*8+4] = k4; keytab[r*8+5] = k5; keytab[r*8+6] = k6; keytab[r*8+7] = k7;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 8; c++)
                mat[r][c] = 1'b0;
        slot_r = 0;
        slot_c = 0;
        slot_exp = 0;
        slot_defer = 1'b0;
        evq.delete();
    endtask

    task automatic tick();
        logic [6:0] exp_row;
        bit         exp_kv;
        int         rr, cc;
        ev_t        e;
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            model_reset();
            check("row_n_in_reset", row_n, 7'h7F);
            check("key_valid_in_reset", key_valid, 0);
            return;
        end
        exp_kv = 1'b0;
        foreach (evq[i]) begin
            if (evq[i].s == cyc - 1) begin
                if (lookup(evq[i].key, rr, cc)) exp_kv = 1'b1;
            end
        end
        exp_row = 7'h7F;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 8; c++)
                if (mat[r][c] && !strobe[c]) exp_row[r] = 1'b0;
        if (slot_defer && cyc == slot_exp) begin
            mat[slot_r][slot_c] = 1'b0;
            slot_defer = 1'b0;
        end
        while (evq.size() > 0 && evq[0].s <= cyc - 2) begin
            e = evq.pop_front();
            if (lookup(e.key, rr, cc)) begin
                if (e.press) begin
                    if (slot_defer) mat[slot_r][slot_c] = 1'b0;
                    mat[rr][cc] = 1'b1;
                    slot_r = rr;
                    slot_c = cc;
                    slot_exp = cyc + H;
                    slot_defer = 1'b0;
                end else if (rr == slot_r && cc == slot_c && cyc < slot_exp) begin
                    slot_defer = 1'b1;
                end else begin
                    mat[rr][cc] = 1'b0;
                end
            end
        end
        check("row_n", row_n, exp_row);
        check("key_valid", key_valid, exp_kv);
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input bit press, input logic [8:0] key);
        ev_t e;
        ps2_key = {~ps2_key[10], press, key};
        e.s = cyc + 1;
        e.press = press;
        e.key = key;
        evq.push_back(e);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 56; i++) keytab[i] = 9'h1FF;
        set_row(0, 9'h1FF, 9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034);
        set_row(1, 9'h033, 9'h043, 9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031, 9'h044);
        set_row(2, 9'h04D, 9'h015, 9'h02D, 9'h01B, 9'h02C, 9'h03C, 9'h02A, 9'h01D);
        set_row(3, 9'h022, 9'h035, 9'h01A, 9'h175, 9'h172, 9'h16B, 9'h174, 9'h029);
        set_row(4, 9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D);
        set_row(5, 9'h03E, 9'h046, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
        set_row(6, 9'h05A, 9'h16C, 9'h076, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h012);
        foreach (keytab[i]) if (keytab[i] != 9'h1FF) pool.push_back(keytab[i]);
        pool.push_back(9'h059);
        pool.push_back(9'h007);
        pool.push_back(9'h011);
        pool.push_back(9'h11C);
        pool.push_back(9'h10E);
        model_reset();

        tick_n(3);
        check("reset_row_n", row_n, 7'h7F);
        check("reset_key_valid", key_valid, 0);
        reset = 1'b0;
        tick_n(3);

        // Press A: key_valid one cycle after capture, row 0 low two cycles later.
        strobe = 8'hFD;
        send(1'b1, 9'h01C);
        tick();
        check("A_key_valid", key_valid, 1);
        tick_n(2);
        check("A_row_strobe_col1", row_n, 7'h7E);
        strobe = 8'hFE;
        tick();
        check("A_row_strobe_col0", row_n, 7'h7F);
        send(1'b0, 9'h01C);
        tick_n(15);

        // Short tap on A is stretched to the hold time.
        strobe = 8'hFD;
        send(1'b1, 9'h01C);
        tick_n(2);
        send(1'b0, 9'h01C);
        tick_n(7);
        check("A_tap_held", row_n, 7'h7E);
        tick();
        check("A_tap_expired", row_n, 7'h7F);
        tick_n(4);

        // UP arrow held long enough that its release is immediate.
        strobe = 8'hF7;
        send(1'b1, 9'h175);
        tick_n(3);
        check("UP_pressed", row_n, 7'h77);
        tick_n(17);
        send(1'b0, 9'h175);
        tick_n(2);
        check("UP_release_pending", row_n, 7'h77);
        tick();
        check("UP_released", row_n, 7'h7F);

        // Both shifts down, release right shift: SHIFT clears.
        strobe = 8'h7F;
        send(1'b1, 9'h012);
        send(1'b1, 9'h059);
        tick_n(3);
        check("SHIFT_on", row_n[6], 0);
        send(1'b0, 9'h059);
        tick_n(12);
        check("SHIFT_off_one_released", row_n[6], 1);
        send(1'b0, 9'h012);
        tick_n(4);

        // Unmapped code: no key_valid, nothing on any column.
        strobe = 8'hFF;
        send(1'b1, 9'h007);
        tick();
        check("unmapped_no_kv", key_valid, 0);
        tick();
        check("unmapped_no_kv_late", key_valid, 0);
        for (int c = 0; c < 8; c++) begin
            strobe = ~(8'h01 << c);
            tick();
            check("unmapped_row_n", row_n, 7'h7F);
        end
        send(1'b0, 9'h007);
        tick_n(4);

        // Reset in the middle of a hold, with a toggle pending across release.
        strobe = 8'h00;
        send(1'b1, 9'h023);
        tick_n(3);
        check("D_before_reset", row_n, 7'h7E);
        reset = 1'b1;
        model_reset();
        ps2_key = {~ps2_key[10], 1'b0, 9'h023};
        #1;
        check("async_reset_row_n", row_n, 7'h7F);
        check("async_reset_kv", key_valid, 0);
        tick_n(2);
        reset = 1'b0;
        repeat (5) begin
            tick();
            check("post_reset_no_event", key_valid, 0);
            check("post_reset_row_n", row_n, 7'h7F);
        end
        send(1'b1, 9'h023);
        tick();
        check("post_reset_D_kv", key_valid, 1);
        tick_n(2);
        check("post_reset_D_row", row_n, 7'h7E);
        send(1'b0, 9'h023);
        tick_n(12);

        // Random traffic, including back-to-back events and strobe changes.
        repeat (1500) begin
            int gap;
            logic [8:0] k;
            k = pool[$urandom_range(0, pool.size() - 1)];
            if ($urandom_range(0, 3) == 0) strobe = 8'($urandom);
            else if ($urandom_range(0, 1) == 0) strobe = ~(8'h01 << $urandom_range(0, 7));
            send(1'($urandom_range(0, 1)), k);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 2);
            tick_n(gap);
        end
        tick_n(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
